// File: rtl/exu_wb_arb_pkg.sv
// Shared types and constants for the execute-to-register-file writeback arbiter.
package exu_wb_arb_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned REG_FILE_ADDR_WIDTH = 5;

  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_SEC = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0]                data;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]                tag;
    logic                           live;
  } wb_entry_t;

endpackage

// File: rtl/exu_wb_arb_if.sv
// Writeback bus: ALU and secondary result streams in, register-file write port out.
interface exu_wb_arb_if
  import exu_wb_arb_pkg::*;
#(
  parameter int unsigned Depth = 4
);

  logic [XLEN-1:0]                alu_wb_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] alu_wb_rd_addr;
  logic                           alu_wb_rd_wr_en;
  logic [XLEN-1:0]                alu_instr_tag;

  logic                           sec_valid;
  logic                           sec_ready;
  logic [XLEN-1:0]                sec_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] sec_rd_addr;
  logic [XLEN-1:0]                sec_instr_tag;

  logic                           rf_wr_en;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_wr_addr;
  logic [XLEN-1:0]                rf_wr_data;
  logic [XLEN-1:0]                wb_instr_tag;
  logic                           wb_src;
  logic [$clog2(Depth):0]         q_count;

  modport master (
    output alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en, alu_instr_tag,
    output sec_valid, sec_data, sec_rd_addr, sec_instr_tag,
    input  sec_ready,
    input  rf_wr_en, rf_wr_addr, rf_wr_data, wb_instr_tag, wb_src, q_count
  );

  modport slave (
    input  alu_wb_data, alu_wb_rd_addr, alu_wb_rd_wr_en, alu_instr_tag,
    input  sec_valid, sec_data, sec_rd_addr, sec_instr_tag,
    output sec_ready,
    output rf_wr_en, rf_wr_addr, rf_wr_data, wb_instr_tag, wb_src, q_count
  );

endinterface

// File: rtl/exu_wb_arb_wb_fifo.sv
// In-order circular buffer of pending secondary writebacks with per-entry WAW kill.
module wb_fifo
  import exu_wb_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  wb_entry_t                      push_entry_i,
  input  logic                           pop_i,
  input  logic                           kill_en_i,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] kill_rd_i,
  output wb_entry_t                      head_o,
  output logic                           empty_o,
  output logic [CntW-1:0]                count_o
);

  logic [XLEN-1:0]                data_q [Depth];
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_q   [Depth];
  logic [XLEN-1:0]                tag_q  [Depth];
  logic [Depth-1:0]               live_q, live_d, kill_match;
  logic [PtrW-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]                count_q;

  always_comb begin
    kill_match = '0;
    for (int i = 0; i < Depth; i++) begin
      kill_match[i] = kill_en_i && (rd_q[i] == kill_rd_i);
    end
  end

  // Kill applies to entries already stored; the pushed entry carries its own live bit.
  always_comb begin
    live_d = live_q & ~kill_match;
    if (push_i) begin
      live_d[wr_ptr_q] = push_entry_i.live;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      data_q[wr_ptr_q] <= push_entry_i.data;
      rd_q[wr_ptr_q]   <= push_entry_i.rd;
      tag_q[wr_ptr_q]  <= push_entry_i.tag;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      live_q  <= live_d;
      count_q <= count_q + CntW'(push_i) - CntW'(pop_i);
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    head_o.data = data_q[rd_ptr_q];
    head_o.rd   = rd_q[rd_ptr_q];
    head_o.tag  = tag_q[rd_ptr_q];
    head_o.live = live_q[rd_ptr_q];
  end

  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter: ALU always wins; secondary results bypass when idle or queue behind it.
module exu_wb_arb
  import exu_wb_arb_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input logic         clk_i,
  input logic         rst_i,
  exu_wb_arb_if.slave bus
);

  wb_entry_t                      head, push_entry;
  logic                           fifo_empty, push, pop, sec_acc, sec_ready;
  logic [CntW-1:0]                count;

  logic                           rf_wr_en_d, rf_wr_en_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] rf_wr_addr_d, rf_wr_addr_q;
  logic [XLEN-1:0]                rf_wr_data_d, rf_wr_data_q;
  logic [XLEN-1:0]                wb_tag_d, wb_tag_q;
  logic                           wb_src_d, wb_src_q;

  // Full-based only, so a pop at full does not open the door in the same cycle.
  assign sec_ready = (count != CntW'(Depth));
  assign sec_acc   = bus.sec_valid & sec_ready;

  always_comb begin
    push_entry.data = bus.sec_data;
    push_entry.rd   = bus.sec_rd_addr;
    push_entry.tag  = bus.sec_instr_tag;
    push_entry.live = !(bus.alu_wb_rd_wr_en && (bus.sec_rd_addr == bus.alu_wb_rd_addr));
  end

  always_comb begin
    push         = sec_acc & (~fifo_empty | bus.alu_wb_rd_wr_en);
    pop          = 1'b0;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    wb_tag_d     = wb_tag_q;
    wb_src_d     = wb_src_q;
    if (bus.alu_wb_rd_wr_en) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = bus.alu_wb_rd_addr;
      rf_wr_data_d = bus.alu_wb_data;
      wb_tag_d     = bus.alu_instr_tag;
      wb_src_d     = WB_SRC_ALU;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      rf_wr_en_d = head.live;
      if (head.live) begin
        rf_wr_addr_d = head.rd;
        rf_wr_data_d = head.data;
        wb_tag_d     = head.tag;
        wb_src_d     = WB_SRC_SEC;
      end
    end else if (sec_acc) begin
      rf_wr_en_d   = 1'b1;
      rf_wr_addr_d = bus.sec_rd_addr;
      rf_wr_data_d = bus.sec_data;
      wb_tag_d     = bus.sec_instr_tag;
      wb_src_d     = WB_SRC_SEC;
    end
  end

  wb_fifo #(
    .Depth (Depth)
  ) u_wb_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_en_i    (bus.alu_wb_rd_wr_en),
    .kill_rd_i    (bus.alu_wb_rd_addr),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .count_o      (count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
      wb_tag_q     <= '0;
      wb_src_q     <= WB_SRC_ALU;
    end else begin
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      wb_tag_q     <= wb_tag_d;
      wb_src_q     <= wb_src_d;
    end
  end

  assign bus.sec_ready    = sec_ready;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.wb_instr_tag = wb_tag_q;
  assign bus.wb_src       = wb_src_q;
  assign bus.q_count      = count;

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed, table-driven bench for the writeback arbiter plus an async-reset sequence.
module tb_exu_wb_arb;
  import exu_wb_arb_pkg::*;

  localparam int unsigned Depth = 4;

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        sec_v;
    logic [4:0]  sec_rd;
    logic [31:0] sec_data;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_src;
    int          e_q;
    logic        e_rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] shadow [32];
  vec_t vq [$];

  exu_wb_arb_if #(.Depth(Depth)) bus ();

  exu_wb_arb #(
    .Depth (Depth)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rf_wr_en) shadow[bus.rf_wr_addr] <= bus.rf_wr_data;
  end

  function automatic vec_t mk(logic we, logic [4:0] ard, logic [31:0] adat,
                              logic sv, logic [4:0] srd, logic [31:0] sdat,
                              logic een, logic [4:0] eaddr, logic [31:0] edata,
                              logic esrc, int eq, logic erdy);
    vec_t v;
    v.alu_we = we;  v.alu_rd = ard; v.alu_data = adat;
    v.sec_v  = sv;  v.sec_rd = srd; v.sec_data = sdat;
    v.e_en   = een; v.e_addr = eaddr; v.e_data = edata;
    v.e_src  = esrc; v.e_q = eq; v.e_rdy = erdy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [4:0] ard, logic [31:0] adat,
                       logic sv, logic [4:0] srd, logic [31:0] sdat);
    bus.alu_wb_rd_wr_en = we;
    bus.alu_wb_rd_addr  = ard;
    bus.alu_wb_data     = adat;
    bus.alu_instr_tag   = 32'h1000 | adat;
    bus.sec_valid       = sv;
    bus.sec_rd_addr     = srd;
    bus.sec_data        = sdat;
    bus.sec_instr_tag   = 32'h2000 | sdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset rf_wr_en", 32'(bus.rf_wr_en), 0);
    chk("reset rf_wr_addr", 32'(bus.rf_wr_addr), 0);
    chk("reset rf_wr_data", bus.rf_wr_data, 0);
    chk("reset wb_instr_tag", bus.wb_instr_tag, 0);
    chk("reset wb_src", 32'(bus.wb_src), 0);
    chk("reset q_count", 32'(bus.q_count), 0);
    chk("reset sec_ready", 32'(bus.sec_ready), 1);

    // ALU only
    for (int i = 0; i < 5; i++) vq.push_back(mk(1, 3, 32'h11, 0, 0, 0, 1, 3, 32'h11, 0, 0, 1));
    // Bypass, then idle
    vq.push_back(mk(0, 0, 0, 1, 5, 32'hAA, 1, 5, 32'hAA, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Fill under ALU traffic; 5th beat held until room appears
    vq.push_back(mk(1, 1, 32'h20, 1, 10, 32'hB0, 1, 1, 32'h20, 0, 1, 1));
    vq.push_back(mk(1, 1, 32'h21, 1, 11, 32'hB1, 1, 1, 32'h21, 0, 2, 1));
    vq.push_back(mk(1, 1, 32'h22, 1, 12, 32'hB2, 1, 1, 32'h22, 0, 3, 1));
    vq.push_back(mk(1, 1, 32'h23, 1, 13, 32'hB3, 1, 1, 32'h23, 0, 4, 0));
    vq.push_back(mk(1, 1, 32'h24, 1, 14, 32'hB4, 1, 1, 32'h24, 0, 4, 0));
    vq.push_back(mk(1, 1, 32'h25, 1, 14, 32'hB4, 1, 1, 32'h25, 0, 4, 0));
    // Drain: pop at full does not accept the held beat
    vq.push_back(mk(0, 0, 0, 1, 14, 32'hB4, 1, 10, 32'hB0, 1, 3, 1));
    vq.push_back(mk(0, 0, 0, 1, 14, 32'hB4, 1, 11, 32'hB1, 1, 3, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12, 32'hB2, 1, 2, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 13, 32'hB3, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 14, 32'hB4, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // WAW kill: queued rd7 and simultaneous rd7 push both die
    vq.push_back(mk(1, 2, 32'h30, 1, 7, 32'h01, 1, 2, 32'h30, 0, 1, 1));
    vq.push_back(mk(1, 7, 32'h02, 1, 7, 32'h03, 1, 7, 32'h02, 0, 2, 1));
    vq.push_back(mk(1, 4, 32'h31, 1, 8, 32'h04, 1, 4, 32'h31, 0, 3, 1));
    vq.push_back(mk(0, 0, 0, 1, 9, 32'h05, 0, 0, 0, 0, 3, 1));
    vq.push_back(mk(0, 0, 0, 1, 6, 32'h06, 0, 0, 0, 0, 3, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8, 32'h04, 1, 2, 1));
    // Simultaneous push/pop at q_count = 2
    vq.push_back(mk(0, 0, 0, 1, 13, 32'h07, 1, 9, 32'h05, 1, 2, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 6, 32'h06, 1, 1, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 13, 32'h07, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (vq[i]) begin
      vec_t v;
      logic [31:0] etag;
      v = vq[i];
      drive(v.alu_we, v.alu_rd, v.alu_data, v.sec_v, v.sec_rd, v.sec_data);
      tick();
      etag = v.e_src ? (32'h2000 | v.e_data) : (32'h1000 | v.e_data);
      chk($sformatf("v%0d rf_wr_en", i), 32'(bus.rf_wr_en), 32'(v.e_en));
      if (v.e_en) begin
        chk($sformatf("v%0d rf_wr_addr", i), 32'(bus.rf_wr_addr), 32'(v.e_addr));
        chk($sformatf("v%0d rf_wr_data", i), bus.rf_wr_data, v.e_data);
        chk($sformatf("v%0d wb_src", i), 32'(bus.wb_src), 32'(v.e_src));
        chk($sformatf("v%0d wb_instr_tag", i), bus.wb_instr_tag, etag);
      end
      chk($sformatf("v%0d q_count", i), 32'(bus.q_count), 32'(v.e_q));
      chk($sformatf("v%0d sec_ready", i), 32'(bus.sec_ready), 32'(v.e_rdy));
    end
    chk("final r7 value", shadow[7], 32'h2);

    // Mid-operation asynchronous reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h40 + 32'(i), 1, 20, 32'h50 + 32'(i));
      tick();
    end
    chk("pre-reset q_count", 32'(bus.q_count), 3);
    chk("pre-reset rf_wr_en", 32'(bus.rf_wr_en), 1);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async rst rf_wr_en", 32'(bus.rf_wr_en), 0);
    chk("async rst rf_wr_addr", 32'(bus.rf_wr_addr), 0);
    chk("async rst rf_wr_data", bus.rf_wr_data, 0);
    chk("async rst wb_instr_tag", bus.wb_instr_tag, 0);
    chk("async rst wb_src", 32'(bus.wb_src), 0);
    chk("async rst q_count", 32'(bus.q_count), 0);
    tick();
    rst = 1'b0;
    chk("post rst sec_ready", 32'(bus.sec_ready), 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post rst idle %0d rf_wr_en", i), 32'(bus.rf_wr_en), 0);
      chk($sformatf("post rst idle %0d q_count", i), 32'(bus.q_count), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exu_wb_arb.md
# exu_wb_arb

Writeback arbiter between the execute units and the register file. It merges the ALU writeback stream with a secondary multi-cycle writeback stream (load/mul), and issues at most one register-file write per cycle. The ALU stream has no backpressure, so it always wins. Secondary results are buffered in a small FIFO and drain in ALU bubbles; a younger ALU write to the same register cancels queued older writes.

## Interface
- `XLEN`, from global.svh: datapath width.
- `REG_FILE_ADDR_WIDTH`, from global.svh: register address width.
- `DEPTH`, default 4: secondary FIFO entries; power of 2, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `alu_wb_data`  in  XLEN  ALU result.
- `alu_wb_rd_addr`  in  REG_FILE_ADDR_WIDTH  ALU destination register.
- `alu_wb_rd_wr_en`  in  1  ALU write request; must be accepted in the same cycle.
- `alu_instr_tag`  in  XLEN  PC/tag of the ALU instruction.
- `sec_valid`  in  1  secondary result valid.
- `sec_ready`  out  1  FIFO can accept.
- `sec_data`  in  XLEN  secondary result.
- `sec_rd_addr`  in  REG_FILE_ADDR_WIDTH  secondary destination.
- `sec_instr_tag`  in  XLEN  secondary tag.
- `rf_wr_en`  out  1  register-file write strobe.
- `rf_wr_addr`  out  REG_FILE_ADDR_WIDTH  write address.
- `rf_wr_data`  out  XLEN  write data.
- `wb_instr_tag`  out  XLEN  tag of the written instruction, for trace.
- `wb_src`  out  1  0 = ALU, 1 = secondary.
- `q_count`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- **Secondary accept:** `sec_valid & sec_ready`. `sec_ready = (q_count != DEPTH)`. `sec_ready` is registered-state based and does not depend on `sec_valid`.
  - At full, a same-cycle pop does not raise `sec_ready`.
- **Arbitration, per cycle, priority order:**
  1. `alu_wb_rd_wr_en = 1`: write the ALU result. No pop.
  2. Otherwise, if the FIFO is non-empty: pop the head. Write it only if its live bit is set; a killed head is popped and `rf_wr_en` stays 0 for that slot.
  3. Otherwise, if the FIFO is empty and a secondary accept occurs: bypass it straight to the output. It is not enqueued.
  4. Otherwise: `rf_wr_en = 0`.
- **Enqueue:** an accepted secondary result is pushed when the FIFO is non-empty or the ALU is writing.
  - If the FIFO is non-empty and there is no ALU write, a push and a pop happen in the same cycle; `q_count` is unchanged.
- **Entry fields:** data, rd, tag, live bit. Live = 1 on push.
- **WAW kill:** when `alu_wb_rd_wr_en = 1`, every queued entry whose rd equals `alu_wb_rd_addr` gets live cleared.
  - A secondary result being pushed in that same cycle with the same rd is also pushed with live = 0. The ALU instruction is younger than anything arriving at writeback alongside it.
- **Ordering:** the FIFO is strictly in order. Pointers wrap modulo DEPTH. `q_count` ranges 0..DEPTH.
- **Reset:**
  - Outputs: `rf_wr_en = 0`, `rf_wr_addr = 0`, `rf_wr_data = 0`, `wb_instr_tag = 0`, `wb_src = 0`, `q_count = 0`, `sec_ready = 1` once reset is released.
  - Pointers and live bits are cleared.
  - Reset asserted mid-operation discards all queued entries immediately, asynchronously.

## Timing
- All `rf_*`, `wb_*` and `q_count` outputs are registered.
- ALU input to `rf_wr_en`: exactly 1 cycle.
- Secondary bypass: 1 cycle.
- Queued entry: 1 cycle after the first ALU-idle cycle in which it is the head.
- Throughput: one write per cycle.
- No starvation guarantee: continuous ALU writes hold the FIFO. Upstream throttles using `sec_ready`.

## Structure
- Shared package (types.svh): `wb_entry_t` (data, rd, tag, live) and the `WB_SRC_ALU` / `WB_SRC_SEC` constants.
- Sub-module `wb_fifo`: a parameterised circular buffer with a per-entry `kill_match` port (rd compare plus kill enable) that clears the live bits. It is instantiated once.
- The arbiter logic and output registers stay in the top level.

## Test plan
- **ALU only:** rd = 3, data = 0x11 for 5 consecutive cycles → `rf_wr_en` is high for 5 cycles, each starting 1 cycle after its input, `wb_src = 0`, `q_count = 0`.
- **Bypass:** idle ALU, one secondary beat (rd = 5, data = 0xAA) → the next cycle shows `rf_wr_en = 1`, addr = 5, data = 0xAA, `wb_src = 1`, and `q_count` stays 0.
- **Fill and drain:**
  - ALU writes every cycle for 6 cycles while the secondary offers 5 beats.
  - Expect 4 accepted, then `sec_ready = 0` and `q_count = 4`; the 5th beat is held.
  - When the ALU goes idle, the entries drain in order, 1 per cycle, and the held beat follows.
- **WAW kill:**
  - Queue rd = 7 (data 0x1) behind ALU traffic, then issue an ALU write to rd = 7 (data 0x2).
  - On drain, the rd = 7 queued slot shows `rf_wr_en = 0`, and the final register value is 0x2.
  - A simultaneous push to rd = 7 in the ALU-write cycle is also killed.
- **Simultaneous push/pop:** with `q_count = 2`, ALU idle and a secondary beat arriving → the head is written and `q_count` stays 2.
- **Mid-operation reset:** with `q_count = 3`, assert `rst` asynchronously mid-cycle → all outputs go to 0 immediately, `q_count = 0`, and no queued entry is written after release.
